// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage: default widths, fetch FSM states
// and the instruction opcode constants used across the pipeline.
package instr_fetch_pkg;

  localparam int ADDR_W_DEF  = 6;
  localparam int INSTR_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } fetch_state_e;

  // Opcode lives in the top nibble of every instruction word.
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_LD   = 4'h3;
  localparam logic [3:0] OP_ST   = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory read port plus the valid/ready
// handshake towards decode.
interface instr_fetch_if #(
  parameter int ADDR_W  = 6,
  parameter int INSTR_W = 16
);
  logic               imem_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;

  modport master (
    output imem_en, imem_addr, instr_out, instr_pc, instr_valid,
    input  imem_rdata, instr_ready
  );

  modport slave (
    input  imem_en, imem_addr, instr_out, instr_pc, instr_valid,
    output imem_rdata, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding read to a 1-cycle-latency memory,
// holds the fetched word for decode, supports redirect and permanent halt.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_fetch_if.master     bus,
  input  logic              load_pc,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_halted
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_out_q, instr_out_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               instr_valid_q, instr_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      instr_out_q   <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_out_q   <= instr_out_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_out_d   = instr_out_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    // Halt beats redirect, redirect beats the decode handshake; HALT is sticky.
    if (state_q != S_HALT && halted) begin
      state_d       = S_HALT;
      instr_valid_d = 1'b0;
    end else if (state_q != S_HALT && load_pc) begin
      state_d       = S_REQ;
      pc_d          = load_addr;
      instr_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ:  state_d = S_WAIT;
        S_WAIT: begin
          instr_out_d   = bus.imem_rdata;
          instr_pc_d    = pc_q;
          pc_d          = pc_q + ADDR_W'(1);
          instr_valid_d = 1'b1;
          state_d       = S_HOLD;
        end
        S_HOLD: begin
          if (instr_valid_q && bus.instr_ready) begin
            instr_valid_d = 1'b0;
            state_d       = S_REQ;
          end
        end
        S_HALT: state_d = S_HALT;
        default: begin
          state_d       = S_IDLE;
          instr_valid_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_en     = (state_q == S_REQ);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_out   = instr_out_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign pc              = pc_q;
  assign fetch_halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with a 1-cycle-latency memory model
// where word k holds 16'h0100 + k.
module tb_instr_fetch;

  logic       clk;
  logic       rst_n;
  logic       load_pc;
  logic [5:0] load_addr;
  logic       halted;
  logic [5:0] pc;
  logic       fetch_halted;

  int checks = 0;
  int passes = 0;

  instr_fetch_if #(.ADDR_W(6), .INSTR_W(16)) bus ();

  instr_fetch #(.ADDR_W(6), .INSTR_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .load_pc      (load_pc),
    .load_addr    (load_addr),
    .halted       (halted),
    .pc           (pc),
    .fetch_halted (fetch_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.imem_en === 1'b1) bus.imem_rdata <= 16'h0100 + {10'b0, bus.imem_addr};

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.instr_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Asynchronous assert mid-cycle, release on a negedge; returns at cycle 1.
  task automatic test_reset();
    bus.instr_ready = 1'b0;
    load_pc = 1'b0; load_addr = '0; halted = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pc !== 6'd0) $display("FAIL rst_pc got %0d exp 0", pc); else passes++;
    checks++; if (bus.instr_out !== 16'h0) $display("FAIL rst_instr_out got %h exp 0000", bus.instr_out); else passes++;
    checks++; if (bus.instr_pc !== 6'd0) $display("FAIL rst_instr_pc got %0d exp 0", bus.instr_pc); else passes++;
    checks++; if (bus.instr_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", bus.instr_valid); else passes++;
    checks++; if (fetch_halted !== 1'b0) $display("FAIL rst_fetch_halted got %b exp 0", fetch_halted); else passes++;
    checks++; if (bus.imem_en !== 1'b0) $display("FAIL rst_imem_en got %b exp 0", bus.imem_en); else passes++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (bus.imem_en !== 1'b0) $display("FAIL rst_c1_imem_en got %b exp 0", bus.imem_en); else passes++;
  endtask

  task automatic test_throughput();
    bit exp_en, exp_v;
    test_reset();
    bus.instr_ready = 1'b1;
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      exp_en = (c == 2 || c == 5 || c == 8);
      exp_v  = (c == 4 || c == 7 || c == 10);
      checks++; if (bus.imem_en !== exp_en) $display("FAIL thr_en c=%0d got %b exp %b", c, bus.imem_en, exp_en); else passes++;
      if (exp_en) begin
        checks++; if (bus.imem_addr !== 6'((c - 2) / 3)) $display("FAIL thr_addr c=%0d got %0d exp %0d", c, bus.imem_addr, (c - 2) / 3); else passes++;
      end
      checks++; if (bus.instr_valid !== exp_v) $display("FAIL thr_valid c=%0d got %b exp %b", c, bus.instr_valid, exp_v); else passes++;
      if (exp_v) begin
        checks++; if (bus.instr_out !== 16'(16'h0100 + (c - 4) / 3)) $display("FAIL thr_out c=%0d got %h exp %h", c, bus.instr_out, 16'h0100 + (c - 4) / 3); else passes++;
        checks++; if (bus.instr_pc !== 6'((c - 4) / 3)) $display("FAIL thr_ipc c=%0d got %0d exp %0d", c, bus.instr_pc, (c - 4) / 3); else passes++;
      end
    end
  endtask

  task automatic test_stall();
    test_reset();
    @(negedge clk); @(negedge clk);
    for (int c = 4; c <= 9; c++) begin
      @(negedge clk);
      checks++; if (bus.instr_valid !== 1'b1) $display("FAIL stall_valid c=%0d got %b exp 1", c, bus.instr_valid); else passes++;
      checks++; if (bus.instr_out !== 16'h0100 || bus.instr_pc !== 6'd0) $display("FAIL stall_hold c=%0d got %h@%0d exp 0100@0", c, bus.instr_out, bus.instr_pc); else passes++;
      checks++; if (bus.imem_en !== 1'b0 || pc !== 6'd1) $display("FAIL stall_en_pc c=%0d got en=%b pc=%0d exp en=0 pc=1", c, bus.imem_en, pc); else passes++;
    end
    bus.instr_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.instr_valid !== 1'b0 || bus.imem_en !== 1'b1 || bus.imem_addr !== 6'd1) $display("FAIL stall_accept got v=%b en=%b addr=%0d exp v=0 en=1 addr=1", bus.instr_valid, bus.imem_en, bus.imem_addr); else passes++;
    @(negedge clk); @(negedge clk);
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_out !== 16'h0101 || bus.instr_pc !== 6'd1) $display("FAIL stall_next got v=%b %h@%0d exp v=1 0101@1", bus.instr_valid, bus.instr_out, bus.instr_pc); else passes++;
  endtask

  task automatic test_redirect_wait();
    bit found, ok;
    test_reset();
    bus.instr_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++; if (bus.instr_valid === 1'b1 && bus.instr_pc === 6'd5) $display("FAIL rw_early_word5 got valid word at 5 exp none"); else passes++;
      if (bus.imem_en === 1'b1 && bus.imem_addr === 6'd5) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) $display("FAIL rw_reach_pc5 got timeout exp REQ at 5"); else passes++;
    @(negedge clk);
    checks++; if (pc !== 6'd5 || bus.imem_en !== 1'b0 || bus.instr_valid !== 1'b0) $display("FAIL rw_wait got pc=%0d en=%b v=%b exp pc=5 en=0 v=0", pc, bus.imem_en, bus.instr_valid); else passes++;
    load_pc = 1'b1; load_addr = 6'd40;
    @(negedge clk);
    load_pc = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0 || bus.imem_en !== 1'b1 || bus.imem_addr !== 6'd40 || pc !== 6'd40) $display("FAIL rw_redirect got v=%b en=%b addr=%0d pc=%0d exp v=0 en=1 addr=40 pc=40", bus.instr_valid, bus.imem_en, bus.imem_addr, pc); else passes++;
    wait_valid(ok);
    checks++; if (!ok) $display("FAIL rw_wait_valid got timeout exp valid"); else passes++;
    checks++; if (bus.instr_pc !== 6'd40 || bus.instr_out !== 16'h0128) $display("FAIL rw_target got %h@%0d exp 0128@40", bus.instr_out, bus.instr_pc); else passes++;
  endtask

  task automatic test_redirect_hold();
    bit ok;
    test_reset();
    bus.instr_ready = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 6'd0) $display("FAIL rh_hold got v=%b ipc=%0d exp v=1 ipc=0", bus.instr_valid, bus.instr_pc); else passes++;
    load_pc = 1'b1; load_addr = 6'd42;
    @(negedge clk);
    load_pc = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0 || bus.imem_en !== 1'b1 || bus.imem_addr !== 6'd42) $display("FAIL rh_redirect got v=%b en=%b addr=%0d exp v=0 en=1 addr=42", bus.instr_valid, bus.imem_en, bus.imem_addr); else passes++;
    wait_valid(ok);
    checks++; if (!ok || bus.instr_pc !== 6'd42 || bus.instr_out !== 16'h012A) $display("FAIL rh_target got ok=%b %h@%0d exp 012A@42", ok, bus.instr_out, bus.instr_pc); else passes++;
    // Redirect to the address already in pc while it is being requested.
    @(negedge clk);
    checks++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 6'd43) $display("FAIL rh_next_req got en=%b addr=%0d exp en=1 addr=43", bus.imem_en, bus.imem_addr); else passes++;
    load_pc = 1'b1; load_addr = 6'd43;
    @(negedge clk);
    load_pc = 1'b0;
    checks++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 6'd43) $display("FAIL rh_same_pc_req got en=%b addr=%0d exp en=1 addr=43", bus.imem_en, bus.imem_addr); else passes++;
    @(negedge clk);
    checks++; if (bus.imem_en !== 1'b0 || bus.instr_valid !== 1'b0) $display("FAIL rh_same_pc_wait got en=%b v=%b exp en=0 v=0", bus.imem_en, bus.instr_valid); else passes++;
    @(negedge clk);
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 6'd43 || bus.instr_out !== 16'h012B) $display("FAIL rh_same_pc_out got v=%b %h@%0d exp v=1 012B@43", bus.instr_valid, bus.instr_out, bus.instr_pc); else passes++;
  endtask

  task automatic test_wrap();
    bit ok;
    test_reset();
    bus.instr_ready = 1'b1;
    @(negedge clk);
    load_pc = 1'b1; load_addr = 6'd63;
    @(negedge clk);
    load_pc = 1'b0;
    checks++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 6'd63) $display("FAIL wrap_req got en=%b addr=%0d exp en=1 addr=63", bus.imem_en, bus.imem_addr); else passes++;
    wait_valid(ok);
    checks++; if (!ok || bus.instr_pc !== 6'd63 || bus.instr_out !== 16'h013F) $display("FAIL wrap_63 got ok=%b %h@%0d exp 013F@63", ok, bus.instr_out, bus.instr_pc); else passes++;
    checks++; if (pc !== 6'd0) $display("FAIL wrap_pc got %0d exp 0", pc); else passes++;
    @(negedge clk);
    checks++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 6'd0) $display("FAIL wrap_req0 got en=%b addr=%0d exp en=1 addr=0", bus.imem_en, bus.imem_addr); else passes++;
    wait_valid(ok);
    checks++; if (!ok || bus.instr_pc !== 6'd0 || bus.instr_out !== 16'h0100) $display("FAIL wrap_0 got ok=%b %h@%0d exp 0100@0", ok, bus.instr_out, bus.instr_pc); else passes++;
  endtask

  task automatic test_halt();
    bit ok;
    int en_seen;
    test_reset();
    bus.instr_ready = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    halted = 1'b1; load_pc = 1'b1; load_addr = 6'd20;
    @(negedge clk);
    halted = 1'b0;
    checks++; if (fetch_halted !== 1'b1 || pc !== 6'd1) $display("FAIL halt_enter got fh=%b pc=%0d exp fh=1 pc=1", fetch_halted, pc); else passes++;
    checks++; if (bus.instr_valid !== 1'b0 || bus.imem_en !== 1'b0) $display("FAIL halt_outputs got v=%b en=%b exp v=0 en=0", bus.instr_valid, bus.imem_en); else passes++;
    load_addr = 6'd9;
    en_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.imem_en !== 1'b0 || bus.instr_valid !== 1'b0) en_seen++;
    end
    load_pc = 1'b0;
    checks++; if (en_seen != 0) $display("FAIL halt_quiet got %0d active cycles exp 0", en_seen); else passes++;
    checks++; if (fetch_halted !== 1'b1 || pc !== 6'd1) $display("FAIL halt_sticky got fh=%b pc=%0d exp fh=1 pc=1", fetch_halted, pc); else passes++;
    test_reset();
    bus.instr_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 6'd0 || fetch_halted !== 1'b0) $display("FAIL halt_restart got en=%b addr=%0d fh=%b exp en=1 addr=0 fh=0", bus.imem_en, bus.imem_addr, fetch_halted); else passes++;
    wait_valid(ok);
    checks++; if (!ok || bus.instr_pc !== 6'd0 || bus.instr_out !== 16'h0100) $display("FAIL halt_refetch got ok=%b %h@%0d exp 0100@0", ok, bus.instr_out, bus.instr_pc); else passes++;
  endtask

  initial begin
    rst_n = 1'b1;
    bus.instr_ready = 1'b0;
    load_pc = 1'b0; load_addr = '0; halted = 1'b0;
    test_throughput();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_halt();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_W, default 6, instruction-memory address width (64 words).
REQ-002 Parameter INSTR_W, default 16, instruction word width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 imem_en  output  1  instruction-memory read request.
REQ-006 imem_addr  output  ADDR_W  read address, always equal to pc.
REQ-007 imem_rdata  input  INSTR_W  read data, valid exactly one cycle after an imem_en cycle.
REQ-008 instr_out  output  INSTR_W  fetched instruction word to decode.
REQ-009 instr_pc  output  ADDR_W  address that instr_out was fetched from.
REQ-010 instr_valid  output  1  instr_out/instr_pc hold a live instruction.
REQ-011 instr_ready  input  1  decode accepts instruction when high together with instr_valid.
REQ-012 load_pc  input  1  redirect request from write-back (jump/taken branch).
REQ-013 load_addr  input  ADDR_W  redirect target.
REQ-014 halted  input  1  HALT retired in write-back.
REQ-015 pc  output  ADDR_W  current fetch address.
REQ-016 fetch_halted  output  1  fetch permanently stopped.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, HOLD, HALT; encoding is binary, one state register.
REQ-018 IDLE: no request; next state REQ unconditionally.
REQ-019 REQ: imem_en=1 combinationally; next state WAIT.
REQ-020 WAIT: capture imem_rdata into instr_out, pc into instr_pc; pc <= pc+1 modulo 2^ADDR_W (63 wraps to 0); set instr_valid; next state HOLD.
REQ-021 HOLD: instr_valid=1, instr_out/instr_pc stable; on instr_valid && instr_ready clear instr_valid, next state REQ; otherwise stay.
REQ-022 Throughput: one instruction per 3 cycles with instr_ready held high; fetch latency REQ-to-instr_valid = 2 cycles.
REQ-023 imem_en is 0 in all states except REQ.
REQ-024 Redirect: load_pc=1 in IDLE/REQ/WAIT/HOLD sets pc <= load_addr, clears instr_valid, discards any in-flight read (WAIT data not captured), next state REQ.
REQ-025 Redirect has priority over instr_ready handshake in the same cycle; the held instruction is counted as not consumed.
REQ-026 halted=1 in any state: next state HALT, instr_valid cleared, pc unchanged; halted has priority over load_pc.
REQ-027 HALT: imem_en=0, instr_valid=0, fetch_halted=1; load_pc and instr_ready ignored; only exit is reset.
REQ-028 load_addr equal to current pc is a legal redirect and refetches that address.

Reset
REQ-029 rst_n low asynchronously forces: state IDLE, pc 0, instr_out 0, instr_pc 0, instr_valid 0, fetch_halted 0, imem_en 0.
REQ-030 Reset mid-fetch (any state, incl. HALT) abandons the operation; first imem_en after release occurs in the second cycle, address 0.

Structure
REQ-031 Shared package holds ADDR_W/INSTR_W defaults and the FSM state constants, alongside the existing opcode constants.
REQ-032 Single module, no sub-modules; the pc incrementer is inline.

Verification
REQ-033 Reset release, instr_ready=1, memory word k = 16'h0100+k -> imem_en pulses at cycles 2,5,8; instr_out 16'h0100, 16'h0101, 16'h0102 with instr_pc 0,1,2.
REQ-034 instr_ready=0 for 5 cycles in HOLD -> instr_out/instr_pc unchanged, imem_en=0, pc already incremented; accepted on first ready cycle.
REQ-035 load_pc=1, load_addr=6'd40 asserted during WAIT for pc=5 -> word 5 never shown valid; next valid instruction has instr_pc=40.
REQ-036 load_pc and instr_ready both high in HOLD -> instruction counted unconsumed, next instr_pc = load_addr.
REQ-037 Fetch from pc=63 -> instr_pc 63 delivered, following fetch at address 0.
REQ-038 halted=1 with load_pc=1 same cycle -> fetch_halted=1 next cycle, pc unchanged, no further imem_en until rst_n pulsed low, then fetch restarts at 0.
